// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control inputs and time/status outputs of countdown_timer
interface countdown_timer_if;
  logic pulse;
  logic load;
  logic [6:0] load_min;
  logic [5:0] load_sec;
  logic start;
  logic stop;
  logic [6:0] min;
  logic [5:0] sec;
  logic borrow;
  logic running;
  logic expired;
  logic alarm;
  modport master(
    output pulse, load, load_min, load_sec, start, stop,
    input min, sec, borrow, running, expired, alarm
  );
  modport slave(
    input pulse, load, load_min, load_sec, start, stop,
    output min, sec, borrow, running, expired, alarm
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss countdown with pause, terminal alarm and load/stop/start/pulse priority
module countdown_timer #(
  parameter int max_min = 99,
  parameter int max_sec = 59,
  parameter int alarm_len = 8
) (
  input logic reset,
  input logic clock,
  countdown_timer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, ALARM = 2'd3;
  logic [1:0] state, n_state;
  logic [6:0] min, n_min;
  logic [5:0] sec, n_sec;
  logic [7:0] ticks, n_ticks;
  logic borrow, n_borrow, expired, n_expired, running, alarm;
  logic last_tick, at_one;
  assign last_tick = ticks == 8'(alarm_len - 1);
  assign at_one = min == 7'd0 && sec == 6'd1;
  always_comb begin
    n_state = state;
    n_min = min;
    n_sec = sec;
    n_ticks = ticks;
    n_borrow = 1'b0;
    n_expired = 1'b0;
    if (bus.load) begin
      n_min = bus.load_min > 7'(max_min) ? 7'(max_min) : bus.load_min;
      n_sec = bus.load_sec > 6'(max_sec) ? 6'(max_sec) : bus.load_sec;
      n_state = IDLE;
      n_ticks = '0;
    end else if (bus.stop && state == RUN) begin
      n_state = PAUSE;
    end else if (bus.stop && state == ALARM) begin
      n_state = IDLE;
      n_ticks = '0;
    end else if (bus.start && (state == IDLE || state == PAUSE)) begin
      n_state = (min != 7'd0 || sec != 7'd0) ? RUN : state;
    end else if (bus.pulse && state == RUN) begin
      // 00:00 is never held in RUN, so a zero seconds field always has minutes to borrow from
      n_borrow = sec == 6'd0;
      n_sec = sec == 6'd0 ? 6'(max_sec) : sec - 6'd1;
      n_min = sec == 6'd0 ? min - 7'd1 : min;
      n_expired = at_one;
      n_state = at_one ? ALARM : RUN;
      n_ticks = '0;
    end else if (bus.pulse && state == ALARM) begin
      n_state = last_tick ? IDLE : ALARM;
      n_ticks = last_tick ? '0 : ticks + 8'd1;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      min <= '0;
      sec <= '0;
      ticks <= '0;
      borrow <= 1'b0;
      expired <= 1'b0;
      running <= 1'b0;
      alarm <= 1'b0;
    end else begin
      state <= n_state;
      min <= n_min;
      sec <= n_sec;
      ticks <= n_ticks;
      borrow <= n_borrow;
      expired <= n_expired;
      running <= n_state == RUN;
      alarm <= n_state == ALARM;
    end
  end
  assign bus.min = min;
  assign bus.sec = sec;
  assign bus.borrow = borrow;
  assign bus.expired = expired;
  assign bus.running = running;
  assign bus.alarm = alarm;
endmodule
